// File: rtl/ones_frame_accumulator.sv
// ones_frame_accumulator: sums per-byte ones counts over a frame and presents the
// saturated total, byte count and status flags on a valid/ready output.
module ones_frame_accumulator #(
  parameter int FRAME_LEN = 16,
  parameter int SUM_W     = 8,
  parameter int THRESH    = 64,
  localparam int NB_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       in_count_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [SUM_W-1:0] out_sum_o,
  output logic [NB_W-1:0]  out_nbytes_o,
  output logic             out_over_o,
  output logic             out_sat_o,
  output logic             out_err_o
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [NB_W-1:0]  nbytes_q, nbytes_d;
  logic             sat_q, sat_d, err_q, err_d, over_q, over_d;
  logic             accept, bad, hold;
  logic [3:0]       c;
  logic [SUM_W:0]   add;
  logic [SUM_W-1:0] sum_nxt;
  assign hold    = state_q == HOLD;
  assign accept  = in_valid_i & in_ready_o;
  assign bad     = in_count_i > 4'd8;
  assign c       = bad ? 4'd8 : in_count_i;
  // one extra adder bit: carry out means the total exceeded the all-ones limit
  assign add     = {1'b0, sum_q} + (SUM_W+1)'(c);
  assign sum_nxt = add[SUM_W] ? {SUM_W{1'b1}} : add[SUM_W-1:0];
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    nbytes_d = nbytes_q;
    sat_d    = sat_q;
    err_d    = err_q;
    over_d   = over_q;
    if (accept) begin
      sum_d    = sum_nxt;
      nbytes_d = nbytes_q + NB_W'(1);
      sat_d    = sat_q | add[SUM_W];
      err_d    = err_q | bad;
      if (in_last_i || nbytes_q == NB_W'(FRAME_LEN - 1)) begin
        state_d = HOLD;
        over_d  = 32'(sum_nxt) >= 32'(THRESH);
      end
    end else if (hold && out_ready_i) begin
      state_d  = ACCUM;
      sum_d    = '0;
      nbytes_d = '0;
      sat_d    = 1'b0;
      err_d    = 1'b0;
      over_d   = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ACCUM;
      sum_q    <= '0;
      nbytes_q <= '0;
      sat_q    <= 1'b0;
      err_q    <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      nbytes_q <= nbytes_d;
      sat_q    <= sat_d;
      err_q    <= err_d;
      over_q   <= over_d;
    end
  end
  // results are only exposed while a frame is being presented
  assign in_ready_o   = (state_q == ACCUM) & ~rst;
  assign out_valid_o  = hold;
  assign out_sum_o    = hold ? sum_q : '0;
  assign out_nbytes_o = hold ? nbytes_q : '0;
  assign out_over_o   = hold & over_q;
  assign out_sat_o    = hold & sat_q;
  assign out_err_o    = hold & err_q;
endmodule

// File: tb/tb_ones_frame_accumulator.sv
// tb_ones_frame_accumulator: directed vectors against a default instance and a
// narrow SUM_W=4 instance driven by the same stimulus.
module tb_ones_frame_accumulator;
  logic       clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 0;
  logic [3:0] in_count = 0;
  logic       a_in_ready, a_out_valid, a_over, a_sat, a_err;
  logic [7:0] a_sum;
  logic [4:0] a_nb;
  logic       b_in_ready, b_out_valid, b_over, b_sat, b_err;
  logic [3:0] b_sum;
  logic [4:0] b_nb;
  int         n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  ones_frame_accumulator u_a (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(a_in_ready),
    .in_count_i(in_count), .in_last_i(in_last), .out_valid_o(a_out_valid),
    .out_ready_i(out_ready), .out_sum_o(a_sum), .out_nbytes_o(a_nb),
    .out_over_o(a_over), .out_sat_o(a_sat), .out_err_o(a_err)
  );

  ones_frame_accumulator #(.SUM_W(4)) u_b (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(b_in_ready),
    .in_count_i(in_count), .in_last_i(in_last), .out_valid_o(b_out_valid),
    .out_ready_i(out_ready), .out_sum_o(b_sum), .out_nbytes_o(b_nb),
    .out_over_o(b_over), .out_sat_o(b_sat), .out_err_o(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] cnt, input logic last);
    chk("ready_before_beat", a_in_ready, 1);
    in_valid = 1;
    in_count = cnt;
    in_last  = last;
    tick();
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic release_frame();
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("rel_valid", a_out_valid, 0);
    chk("rel_ready", a_in_ready, 1);
    chk("rel_sum", a_sum, 0);
    chk("rel_nbytes", a_nb, 0);
  endtask

  initial begin
    // reset
    tick();
    chk("rst_ready", a_in_ready, 0);
    chk("rst_valid", a_out_valid, 0);
    chk("rst_sum", a_sum, 0);
    @(negedge clk);
    rst = 0;
    tick();
    chk("post_rst_ready", a_in_ready, 1);

    // full frame of 16 beats of 8
    for (int i = 0; i < 15; i++) send(4'd8, 1'b0);
    chk("t2_not_yet", a_out_valid, 0);
    send(4'd8, 1'b0);
    chk("t2_valid", a_out_valid, 1);
    chk("t2_sum", a_sum, 128);
    chk("t2_nbytes", a_nb, 16);
    chk("t2_over", a_over, 1);
    chk("t2_sat", a_sat, 0);
    chk("t2_err", a_err, 0);
    chk("t2_ready", a_in_ready, 0);
    release_frame();

    // short frame with gaps
    send(4'd1, 1'b0);
    tick(); tick();
    send(4'd2, 1'b0);
    tick();
    chk("t3_gap_valid", a_out_valid, 0);
    send(4'd3, 1'b1);
    chk("t3_valid", a_out_valid, 1);
    chk("t3_sum", a_sum, 6);
    chk("t3_nbytes", a_nb, 3);
    chk("t3_over", a_over, 0);
    release_frame();

    // backpressure in HOLD
    send(4'd5, 1'b1);
    in_valid = 1;
    in_count = 4'd7;
    in_last  = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_valid", a_out_valid, 1);
      chk("t4_sum", a_sum, 5);
      chk("t4_nbytes", a_nb, 1);
      chk("t4_ready", a_in_ready, 0);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("t4_rel_valid", a_out_valid, 0);
    chk("t4_rel_ready", a_in_ready, 1);
    tick();
    in_valid = 0;
    in_last  = 0;
    chk("t4_next_sum", a_sum, 7);
    chk("t4_next_nbytes", a_nb, 1);
    release_frame();

    // saturation on the narrow instance
    send(4'd8, 1'b0);
    send(4'd8, 1'b1);
    chk("t5_b_valid", b_out_valid, 1);
    chk("t5_b_sum", b_sum, 15);
    chk("t5_b_sat", b_sat, 1);
    chk("t5_a_sum", a_sum, 16);
    chk("t5_a_sat", a_sat, 0);
    release_frame();
    send(4'd3, 1'b1);
    chk("t5_b_sum2", b_sum, 3);
    chk("t5_b_sat2", b_sat, 0);
    release_frame();

    // illegal count clamps and flags
    send(4'd12, 1'b1);
    chk("t6_sum", a_sum, 8);
    chk("t6_err", a_err, 1);
    chk("t6_nbytes", a_nb, 1);
    release_frame();

    // reset mid-frame discards it
    for (int i = 0; i < 5; i++) send(4'd2, 1'b0);
    #2 rst = 1;
    #1;
    chk("t6_rst_ready", a_in_ready, 0);
    tick();
    chk("t6_rst_valid", a_out_valid, 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t6_no_output", a_out_valid, 0);
    end
    send(4'd4, 1'b0);
    send(4'd1, 1'b1);
    chk("t6_after_sum", a_sum, 5);
    chk("t6_after_nbytes", a_nb, 2);
    chk("t6_after_err", a_err, 0);
    release_frame();

    // in_last on the 16th beat closes the frame only once
    for (int i = 0; i < 15; i++) send(4'd1, 1'b0);
    send(4'd1, 1'b1);
    chk("t7_sum", a_sum, 16);
    chk("t7_nbytes", a_nb, 16);
    chk("t7_over", a_over, 0);
    release_frame();
    tick();
    chk("t7_idle_valid", a_out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
